csr_file: RTL and testbench

//  Parametrised machine-mode CSR file; successor to the fixed four-register CSR bank.

---
 rtl/csr_if.sv | 41 ++++
 rtl/csr_file.sv | 179 +++++++++++++++++
 tb/tb_csr_file.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_if.sv
`default_nettype none
// ============================================================================
//  Module      : csr_if
//  Description : Bundle between the EXU/IFU side (master) and the
//                machine-mode CSR file (slave).
//                master drives: csr_addr, csr_op, csr_wdata, trap_valid,
//                  trap_pc, trap_cause, mret_valid, instret_inc
//                slave drives : csr_rdata, csr_illegal, mtvec_out,
//                  mepc_out, mstatus_out
//  Revision    : 1.0 - initial release
// ============================================================================
interface csr_if #(
  parameter int XLEN = 32
);
  logic [11:0]     csr_addr;
  logic [1:0]      csr_op;
  logic [XLEN-1:0] csr_wdata;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic [XLEN-1:0] trap_cause;
  logic            mret_valid;
  logic            instret_inc;
  logic [XLEN-1:0] mtvec_out;
  logic [XLEN-1:0] mepc_out;
  logic [XLEN-1:0] mstatus_out;

  modport master (
    output csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret_valid, instret_inc,
    input  csr_rdata, csr_illegal, mtvec_out, mepc_out, mstatus_out
  );

  modport slave (
    input  csr_addr, csr_op, csr_wdata, trap_valid, trap_pc, trap_cause,
           mret_valid, instret_inc,
    output csr_rdata, csr_illegal, mtvec_out, mepc_out, mstatus_out
  );
endinterface
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : csr_file
//  Description : Machine-mode CSR file: CSRRW/CSRRS/CSRRC access, trap entry
//                and mret update of mstatus/mepc/mcause, mscratch, and 64-bit
//                mcycle/minstret counters.
//  Ports       : clk    - clock
//                rst_n  - asynchronous active-low reset
//                i_bus  - csr_if slave (address/op/data, trap/mret events,
//                         read data, illegal flag, mtvec/mepc/mstatus outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_file #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] MSTATUS_RST  = XLEN'(32'h1800),
  parameter logic [XLEN-1:0] MTVEC_RST    = '0,
  parameter int              HAS_COUNTERS = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  csr_if.slave  i_bus
);

  localparam logic [1:0]  c_OP_NONE = 2'b00;
  localparam logic [1:0]  c_OP_RW   = 2'b01;
  localparam logic [1:0]  c_OP_RS   = 2'b10;

  localparam logic [11:0] c_MSTATUS  = 12'h300;
  localparam logic [11:0] c_MTVEC    = 12'h305;
  localparam logic [11:0] c_MSCRATCH = 12'h340;
  localparam logic [11:0] c_MEPC     = 12'h341;
  localparam logic [11:0] c_MCAUSE   = 12'h342;
  localparam logic [11:0] c_MCYCLE   = 12'hB00;
  localparam logic [11:0] c_MCYCLEH  = 12'hB80;
  localparam logic [11:0] c_MINSTR   = 12'hB02;
  localparam logic [11:0] c_MINSTRH  = 12'hB82;

  // Direct-mode only: low two bits of mtvec/mepc are hardwired to zero.
  localparam logic [XLEN-1:0] c_ALIGN = ~XLEN'(3);

  logic            r_mie;
  logic            r_mpie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mscratch;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;
  logic [63:0]     r_mcycle;
  logic [63:0]     r_minstret;

  logic            w_is_csr;
  logic            w_is_cnt;
  logic            w_is_id;
  logic            w_write_req;
  logic            w_illegal;
  logic            w_we;
  logic [XLEN-1:0] w_old;
  logic [XLEN-1:0] w_new;
  logic [XLEN-1:0] w_mstatus;

  // Only MIE/MPIE are stored; MPP reads as 11 and everything else as 0.
  always_comb begin
    w_mstatus        = '0;
    w_mstatus[12:11] = 2'b11;
    w_mstatus[7]     = r_mpie;
    w_mstatus[3]     = r_mie;
  end

  always_comb begin
    w_is_csr = i_bus.csr_addr inside {c_MSTATUS, c_MTVEC, c_MSCRATCH, c_MEPC, c_MCAUSE};
    w_is_cnt = i_bus.csr_addr inside {c_MCYCLE, c_MCYCLEH, c_MINSTR, c_MINSTRH};
    w_is_id  = (i_bus.csr_addr >= 12'hF11) && (i_bus.csr_addr <= 12'hF14);

    // RS/RC with a zero operand is a pure read and never writes.
    w_write_req = (i_bus.csr_op == c_OP_RW) ||
                  ((i_bus.csr_op != c_OP_NONE) && (i_bus.csr_wdata != '0));

    w_illegal = (i_bus.csr_op != c_OP_NONE) &&
                (!(w_is_csr || w_is_cnt || w_is_id) ||
                 (w_is_cnt && (HAS_COUNTERS == 0)) ||
                 (w_is_id && w_write_req));

    w_we = w_write_req && !w_illegal;

    case (i_bus.csr_addr)
      c_MSTATUS:  w_old = w_mstatus;
      c_MTVEC:    w_old = r_mtvec;
      c_MSCRATCH: w_old = r_mscratch;
      c_MEPC:     w_old = r_mepc;
      c_MCAUSE:   w_old = r_mcause;
      c_MCYCLE:   w_old = XLEN'(r_mcycle[31:0]);
      c_MCYCLEH:  w_old = XLEN'(r_mcycle[63:32]);
      c_MINSTR:   w_old = XLEN'(r_minstret[31:0]);
      c_MINSTRH:  w_old = XLEN'(r_minstret[63:32]);
      default:    w_old = '0;
    endcase

    case (i_bus.csr_op)
      c_OP_RW: w_new = i_bus.csr_wdata;
      c_OP_RS: w_new = w_old | i_bus.csr_wdata;
      default: w_new = w_old & ~i_bus.csr_wdata;
    endcase
  end

  assign i_bus.csr_rdata   = ((i_bus.csr_op == c_OP_NONE) || w_illegal) ? '0 : w_old;
  assign i_bus.csr_illegal = w_illegal;
  assign i_bus.mtvec_out   = r_mtvec;
  assign i_bus.mepc_out    = r_mepc;
  assign i_bus.mstatus_out = w_mstatus;

  // Priority trap > mret > CSR write, applied only where the winner writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mie  <= MSTATUS_RST[3];
      r_mpie <= MSTATUS_RST[7];
    end else if (i_bus.trap_valid) begin
      r_mpie <= r_mie;
      r_mie  <= 1'b0;
    end else if (i_bus.mret_valid) begin
      r_mie  <= r_mpie;
      r_mpie <= 1'b1;
    end else if (w_we && (i_bus.csr_addr == c_MSTATUS)) begin
      r_mie  <= w_new[3];
      r_mpie <= w_new[7];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtvec    <= MTVEC_RST;
      r_mscratch <= '0;
      r_mepc     <= '0;
      r_mcause   <= '0;
    end else begin
      if (w_we && (i_bus.csr_addr == c_MTVEC))    r_mtvec    <= w_new & c_ALIGN;
      if (w_we && (i_bus.csr_addr == c_MSCRATCH)) r_mscratch <= w_new;
      if (i_bus.trap_valid) begin
        r_mepc   <= i_bus.trap_pc & c_ALIGN;
        r_mcause <= i_bus.trap_cause;
      end else begin
        if (w_we && (i_bus.csr_addr == c_MEPC))   r_mepc     <= w_new & c_ALIGN;
        if (w_we && (i_bus.csr_addr == c_MCAUSE)) r_mcause   <= w_new;
      end
    end
  end

  generate
    if (HAS_COUNTERS != 0) begin : g_counters
      // A write to either half replaces it and skips that cycle's increment;
      // the 64-bit add carries low into high in the same cycle.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_mcycle <= '0;
        else if (w_we && (i_bus.csr_addr == c_MCYCLE))
          r_mcycle <= {r_mcycle[63:32], w_new[31:0]};
        else if (w_we && (i_bus.csr_addr == c_MCYCLEH))
          r_mcycle <= {w_new[31:0], r_mcycle[31:0]};
        else
          r_mcycle <= r_mcycle + 64'd1;
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          r_minstret <= '0;
        else if (w_we && (i_bus.csr_addr == c_MINSTR))
          r_minstret <= {r_minstret[63:32], w_new[31:0]};
        else if (w_we && (i_bus.csr_addr == c_MINSTRH))
          r_minstret <= {w_new[31:0], r_minstret[31:0]};
        else if (i_bus.instret_inc)
          r_minstret <= r_minstret + 64'd1;
      end
    end else begin : g_no_counters
      // Counter addresses are illegal here, so the values are never observed.
      assign r_mcycle   = '0;
      assign r_minstret = '0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_file
//  Description : Self-checking bench for csr_file: directed vector table,
//                hand sequences for counters and async reset, and random
//                traffic compared against a register-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_file;
  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  csr_if #(.XLEN(XLEN)) bus ();

  csr_file #(
    .XLEN(XLEN), .MSTATUS_RST(32'h1800), .MTVEC_RST(32'h0), .HAS_COUNTERS(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .i_bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model: whole architectural registers --------
  typedef struct packed {
    logic [31:0] mstatus, mtvec, mscratch, mepc, mcause;
    logic [63:0] cyc, ins;
  } model_t;
  model_t m;

  function automatic model_t m_reset();
    model_t r;
    r = '0;
    r.mstatus = 32'h1800;
    return r;
  endfunction

  function automatic bit is_id(logic [11:0] a);
    return (a >= 12'hF11) && (a <= 12'hF14);
  endfunction

  function automatic bit is_mapped(logic [11:0] a);
    return (a == 12'h300) || (a == 12'h305) || (a == 12'h340) || (a == 12'h341) ||
           (a == 12'h342) || (a == 12'hB00) || (a == 12'hB80) || (a == 12'hB02) ||
           (a == 12'hB82) || is_id(a);
  endfunction

  function automatic logic [31:0] m_read(model_t s, logic [11:0] a);
    case (a)
      12'h300: return s.mstatus;
      12'h305: return s.mtvec;
      12'h340: return s.mscratch;
      12'h341: return s.mepc;
      12'h342: return s.mcause;
      12'hB00: return s.cyc[31:0];
      12'hB80: return s.cyc[63:32];
      12'hB02: return s.ins[31:0];
      12'hB82: return s.ins[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal(logic [11:0] a, logic [1:0] op, logic [31:0] wd);
    bit wr;
    wr = (op == 2'b01) || (op != 2'b00 && wd != 0);
    return (op != 2'b00) && (!is_mapped(a) || (is_id(a) && wr));
  endfunction

  function automatic model_t m_next(model_t s, logic [11:0] a, logic [1:0] op,
                                    logic [31:0] wd, bit tr, logic [31:0] tpc,
                                    logic [31:0] cause, bit mr, bit inc);
    model_t n;
    logic [31:0] old, nv;
    bit we, cw, iw;
    n   = s;
    we  = !m_illegal(a, op, wd) && ((op == 2'b01) || (op != 2'b00 && wd != 0));
    old = m_read(s, a);
    nv  = (op == 2'b01) ? wd : (op == 2'b10) ? (old | wd) : (old & ~wd);
    cw  = 0;
    iw  = 0;
    if (we) begin
      case (a)
        12'h300: n.mstatus  = (nv & 32'h88) | 32'h1800;
        12'h305: n.mtvec    = nv & ~32'h3;
        12'h340: n.mscratch = nv;
        12'h341: n.mepc     = nv & ~32'h3;
        12'h342: n.mcause   = nv;
        12'hB00: begin n.cyc[31:0]  = nv; cw = 1; end
        12'hB80: begin n.cyc[63:32] = nv; cw = 1; end
        12'hB02: begin n.ins[31:0]  = nv; iw = 1; end
        12'hB82: begin n.ins[63:32] = nv; iw = 1; end
        default: ;
      endcase
    end
    if (!cw) n.cyc = s.cyc + 64'd1;
    if (!iw && inc) n.ins = s.ins + 64'd1;
    if (mr) n.mstatus = 32'h1880 | (s.mstatus[7] ? 32'h8 : 32'h0);
    if (tr) begin
      n.mstatus = 32'h1800 | (s.mstatus[3] ? 32'h80 : 32'h0);
      n.mepc    = tpc & ~32'h3;
      n.mcause  = cause;
    end
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m <= m_reset();
    else m <= m_next(m, bus.csr_addr, bus.csr_op, bus.csr_wdata, bus.trap_valid,
                     bus.trap_pc, bus.trap_cause, bus.mret_valid, bus.instret_inc);
  end

  // ---------------- helpers -----------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                       input bit tr, input logic [31:0] tpc, input logic [31:0] cause,
                       input bit mr, input bit inc);
    bus.csr_addr    = a;
    bus.csr_op      = op;
    bus.csr_wdata   = wd;
    bus.trap_valid  = tr;
    bus.trap_pc     = tpc;
    bus.trap_cause  = cause;
    bus.mret_valid  = mr;
    bus.instret_inc = inc;
  endtask

  // One cycle: drive after the falling edge, check against the model, and
  // let the following rising edge commit.
  task automatic run_cycle(input logic [11:0] a, input logic [1:0] op, input logic [31:0] wd,
                           input bit tr, input logic [31:0] tpc, input logic [31:0] cause,
                           input bit mr, input bit inc,
                           output logic [31:0] rd, output bit ill);
    bit e_ill;
    @(negedge clk);
    drive(a, op, wd, tr, tpc, cause, mr, inc);
    #1;
    rd    = bus.csr_rdata;
    ill   = bus.csr_illegal;
    e_ill = m_illegal(a, op, wd);
    chk("model illegal", {31'b0, ill}, {31'b0, e_ill});
    chk("model rdata", rd, (op == 2'b00 || e_ill) ? 32'h0 : m_read(m, a));
    chk("model mtvec_out", bus.mtvec_out, m.mtvec);
    chk("model mepc_out", bus.mepc_out, m.mepc);
    chk("model mstatus_out", bus.mstatus_out, m.mstatus);
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    bit ill;
    run_cycle(a, 2'b10, 32'h0, 0, 32'h0, 32'h0, 0, 0, rd, ill);
    chk(name, rd, exp);
  endtask

  // ---------------- directed vector table ---------------------------------
  typedef struct {
    logic [11:0] a;
    logic [1:0]  op;
    logic [31:0] wd;
    bit          tr;
    logic [31:0] tpc;
    logic [31:0] cause;
    bit          mr;
    logic [31:0] exp_rd;
    bit          exp_ill;
  } vec_t;

  function automatic vec_t v(logic [11:0] a, logic [1:0] op, logic [31:0] wd, bit tr,
                             logic [31:0] tpc, logic [31:0] cause, bit mr,
                             logic [31:0] exp_rd, bit exp_ill);
    vec_t r;
    r = '{a, op, wd, tr, tpc, cause, mr, exp_rd, exp_ill};
    return r;
  endfunction

  initial begin
    vec_t        tv[$];
    logic [31:0] rd;
    bit          ill;
    logic [11:0] alist[16];

    rst_n = 1'b0;
    drive(12'h0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    repeat (2) @(negedge clk);
    #1;
    chk("reset mstatus_out", bus.mstatus_out, 32'h1800);
    chk("reset mtvec_out", bus.mtvec_out, 32'h0);
    chk("reset mepc_out", bus.mepc_out, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // mcycle counts 1,2,3 after reset release
    for (int k = 1; k <= 3; k++) rd_chk($sformatf("mcycle after reset #%0d", k), 12'hB00, k);

    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h1800,     0));
    tv.push_back(v(12'h305, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,        0));
    tv.push_back(v(12'h305, 2'b01, 32'h80000101, 0, 32'h0,        32'h0, 0, 32'h0,        0));
    tv.push_back(v(12'h305, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h80000100, 0));
    tv.push_back(v(12'h300, 2'b10, 32'h8,        0, 32'h0,        32'h0, 0, 32'h1800,     0));
    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h1808,     0));
    tv.push_back(v(12'h300, 2'b11, 32'h8,        0, 32'h0,        32'h0, 0, 32'h1808,     0));
    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h1800,     0));
    tv.push_back(v(12'h300, 2'b10, 32'h8,        0, 32'h0,        32'h0, 0, 32'h1800,     0));
    tv.push_back(v(12'h000, 2'b00, 32'h0,        1, 32'h80000046, 32'hB, 0, 32'h0,        0));
    tv.push_back(v(12'h341, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h80000044, 0));
    tv.push_back(v(12'h342, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'hB,        0));
    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 1, 32'h1880,     0));
    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h1888,     0));
    tv.push_back(v(12'h341, 2'b01, 32'h5,        1, 32'h100,      32'h2, 0, 32'h80000044, 0));
    tv.push_back(v(12'h341, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h100,      0));
    tv.push_back(v(12'h340, 2'b01, 32'h5,        1, 32'h200,      32'h3, 0, 32'h0,        0));
    tv.push_back(v(12'h340, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h5,        0));
    tv.push_back(v(12'h342, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h3,        0));
    tv.push_back(v(12'h7C0, 2'b01, 32'h1234,     0, 32'h0,        32'h0, 0, 32'h0,        1));
    tv.push_back(v(12'hF11, 2'b01, 32'h1,        0, 32'h0,        32'h0, 0, 32'h0,        1));
    tv.push_back(v(12'hF11, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,        0));
    tv.push_back(v(12'hF12, 2'b11, 32'h1,        0, 32'h0,        32'h0, 0, 32'h0,        1));
    tv.push_back(v(12'h7C0, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,        1));
    tv.push_back(v(12'h340, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h5,        0));
    tv.push_back(v(12'h300, 2'b01, 32'hFFFFFFFF, 0, 32'h0,        32'h0, 0, 32'h1800,     0));
    tv.push_back(v(12'h300, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h1888,     0));
    tv.push_back(v(12'h300, 2'b00, 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,        0));
    tv.push_back(v(12'h305, 2'b01, 32'h3,        0, 32'h0,        32'h0, 0, 32'h80000100, 0));
    tv.push_back(v(12'h305, 2'b10, 32'h0,        0, 32'h0,        32'h0, 0, 32'h0,        0));

    foreach (tv[i]) begin
      run_cycle(tv[i].a, tv[i].op, tv[i].wd, tv[i].tr, tv[i].tpc, tv[i].cause, tv[i].mr, 0, rd, ill);
      chk($sformatf("vec%0d rdata", i), rd, tv[i].exp_rd);
      chk($sformatf("vec%0d illegal", i), {31'b0, ill}, {31'b0, tv[i].exp_ill});
    end

    // mcycle wrap: write both halves to all-ones, hold one cycle, then wrap
    run_cycle(12'hB00, 2'b01, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0, rd, ill);
    run_cycle(12'hB80, 2'b01, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0, rd, ill);
    rd_chk("mcycle held all-ones", 12'hB00, 32'hFFFFFFFF);
    rd_chk("mcycleh after wrap", 12'hB80, 32'h0);
    rd_chk("mcycle counts after wrap", 12'hB00, 32'h1);

    // minstret low-half carry into high half
    run_cycle(12'hB02, 2'b01, 32'hFFFFFFFF, 0, 32'h0, 32'h0, 0, 0, rd, ill);
    run_cycle(12'h000, 2'b00, 32'h0, 0, 32'h0, 32'h0, 0, 1, rd, ill);
    rd_chk("minstreth after carry", 12'hB82, 32'h1);

    // async reset mid-operation: pending write and trap are lost
    @(negedge clk);
    drive(12'h340, 2'b01, 32'hAA, 1, 32'h44, 32'h7, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async reset mstatus_out", bus.mstatus_out, 32'h1800);
    chk("async reset mepc_out", bus.mepc_out, 32'h0);
    chk("async reset mscratch rdata", bus.csr_rdata, 32'h0);
    @(negedge clk);
    drive(12'h0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    rst_n = 1'b1;
    rd_chk("mscratch after reset", 12'h340, 32'h0);
    rd_chk("mcycle restarts", 12'hB00, 32'h2);

    // random traffic against the model
    alist = '{12'h300, 12'h305, 12'h340, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02,
              12'hB82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123, 12'h300};
    for (int i = 0; i < 400; i++) begin
      logic [31:0] wd;
      wd = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      run_cycle(alist[$urandom_range(0, 15)], 2'($urandom_range(0, 3)), wd,
                ($urandom_range(0, 9) == 0), $urandom, $urandom,
                ($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), rd, ill);
    end

    @(negedge clk);
    drive(12'h0, 2'b00, 32'h0, 0, 32'h0, 32'h0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
